somador_serial: RTL and testbench

SOMADOR_SERIAL -- requirements
Module: somador_serial

---
 rtl/somador_serial_if.sv | 33 +++
 rtl/somador_serial.sv | 131 +++++++++++++
 tb/tb_somador_serial.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/somador_serial_if.sv
// Handshake/operand bundle for the bit-serial adder somador_serial.
// Optional macro SOMADOR_OVERFLOW_EN adds the signed-overflow flag.
interface somador_serial_if #(
   parameter int N = 8
);
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [N-1:0] soma;
   logic         cout;
`ifdef SOMADOR_OVERFLOW_EN
   logic         overflow;
`endif

   modport master (
      output start, a, b, cin,
`ifdef SOMADOR_OVERFLOW_EN
      input  overflow,
`endif
      input  busy, done, soma, cout
   );

   modport slave (
      input  start, a, b, cin,
`ifdef SOMADOR_OVERFLOW_EN
      output overflow,
`endif
      output busy, done, soma, cout
   );
endinterface

// File: rtl/somador_serial.sv
// Bit-serial N-bit adder: one full-adder cell, LSB first, one bit per clock.
// Optional macro SOMADOR_OVERFLOW_EN adds a registered signed-overflow flag.
module somador_serial #(
   parameter int N = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   somador_serial_if.slave    bus
);
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, FIM} state_t;

   state_t         r_state;
   state_t         w_next;
   logic [N-1:0]   r_a;
   logic [N-1:0]   r_b;
   logic [N-1:0]   r_part;
   logic           r_carry;
   logic [CW-1:0]  r_cnt;
   logic           r_busy;
   logic           r_done;
   logic [N-1:0]   r_soma;
   logic           r_cout;
   logic           w_load;
   logic           w_step;
   logic           w_fin;
   logic           w_sum;
   logic           w_cy;

   assign w_sum = r_a[0] ^ r_b[0] ^ r_carry;
   assign w_cy  = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);

   always_comb begin
      w_next = r_state;
      w_load = 1'b0;
      w_step = 1'b0;
      w_fin  = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_load = 1'b1;
               w_next = SHIFT;
            end
         end
         SHIFT: begin
            // N step cycles, then one cycle that publishes the result
            if (r_cnt == CW'(N)) begin
               w_fin  = 1'b1;
               w_next = FIM;
            end else begin
               w_step = 1'b1;
            end
         end
         FIM: begin
            if (bus.start) begin
               w_load = 1'b1;
               w_next = SHIFT;
            end else begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_part  <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_soma  <= '0;
         r_cout  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next == SHIFT);
         r_done  <= w_fin;
         if (w_load) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.cin;
            r_cnt   <= '0;
            r_part  <= '0;
         end else if (w_step) begin
            r_part  <= {w_sum, r_part[N-1:1]};
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_carry <= w_cy;
            r_cnt   <= r_cnt + 1'b1;
         end
         if (w_fin) begin
            r_soma <= r_part;
            r_cout <= r_carry;
         end
      end
   end

`ifdef SOMADOR_OVERFLOW_EN
   logic r_cmsb;
   logic r_ovf;

   // carry entering the MSB cell is the carry flop during the last step
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmsb <= 1'b0;
         r_ovf  <= 1'b0;
      end else begin
         if (w_load) begin
            r_cmsb <= 1'b0;
         end else if (w_step && (r_cnt == CW'(N - 1))) begin
            r_cmsb <= r_carry;
         end
         if (w_fin) begin
            r_ovf <= r_cmsb ^ r_carry;
         end
      end
   end

   assign bus.overflow = r_ovf;
`endif

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.soma = r_soma;
   assign bus.cout = r_cout;
endmodule

// File: tb/tb_somador_serial.sv
// Directed self-checking bench for somador_serial (N=8).
// Overflow checks compile in only when SOMADOR_OVERFLOW_EN is defined.
module tb_somador_serial;
   localparam int N = 8;

   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;
   int   lat;
   int   pulses;
   logic [N-1:0] held;

   always #5 clk = ~clk;

   somador_serial_if #(.N(N)) bus ();

   somador_serial #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // returns at the first negedge where done is seen; lat counts negedges
   task automatic wait_done(input int lat0, output int lat_o);
      lat_o = lat0;
      while (bus.done !== 1'b1 && lat_o < 40) begin
         @(negedge clk);
         lat_o++;
      end
   endtask

   // leaves the bench at the negedge right after the loading edge
   task automatic start_op(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tc);
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = ta;
      bus.b     = tb;
      bus.cin   = tc;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic finish_op(input string tag, input int lat0, input logic [N-1:0] es,
                            input logic ec, input logic eo);
      int l;
      wait_done(lat0, l);
      check({tag, "_latency"}, l, N + 1);
      check({tag, "_soma"}, bus.soma, es);
      check({tag, "_cout"}, bus.cout, ec);
`ifdef SOMADOR_OVERFLOW_EN
      check({tag, "_ovf"}, bus.overflow, eo);
`else
      if (eo === 1'bx) $display("unreachable");
`endif
      @(negedge clk);
      check({tag, "_done_pulse"}, bus.done, 1'b0);
      check({tag, "_busy_after"}, bus.busy, 1'b0);
   endtask

   initial begin
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.cin   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_done", bus.done, 1'b0);
      check("rst_soma", bus.soma, 8'h00);
      check("rst_cout", bus.cout, 1'b0);
`ifdef SOMADOR_OVERFLOW_EN
      check("rst_ovf", bus.overflow, 1'b0);
`endif
      rst_n = 1'b1;

      // 0x5A + 0x3C = 0x96, signed overflow
      start_op(8'h5A, 8'h3C, 1'b0);
      check("op1_busy", bus.busy, 1'b1);
      finish_op("op1", 0, 8'h96, 1'b0, 1'b1);

      // 0xFF + 0x01 wraps to 0 with carry out
      start_op(8'hFF, 8'h01, 1'b0);
      finish_op("op2", 0, 8'h00, 1'b1, 1'b0);

      // start pulsed mid-operation must be ignored; operands change too
      start_op(8'h7F, 8'h01, 1'b1);
      held = bus.soma;
      repeat (3) @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 8'h00;
      bus.b     = 8'hFF;
      bus.cin   = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      check("op3_busy_mid", bus.busy, 1'b1);
      check("op3_soma_held", bus.soma, held);
      finish_op("op3", 4, 8'h81, 1'b0, 1'b1);

      // reset during SHIFT aborts with no done pulse
      start_op(8'h55, 8'hAA, 1'b0);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("arst_busy", bus.busy, 1'b0);
      check("arst_done", bus.done, 1'b0);
      check("arst_soma", bus.soma, 8'h00);
      check("arst_cout", bus.cout, 1'b0);
      @(negedge clk);
      rst_n  = 1'b1;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) pulses++;
      end
      check("arst_no_done", pulses, 0);
      start_op(8'h01, 8'h02, 1'b1);
      finish_op("op4", 0, 8'h04, 1'b0, 1'b0);

      // start held through FIM: second op begins with no idle cycle
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 8'h0A;
      bus.b     = 8'h14;
      bus.cin   = 1'b0;
      @(negedge clk);
      bus.a     = 8'hC8;
      bus.b     = 8'h64;
      wait_done(0, lat);
      check("b2b1_latency", lat, N + 1);
      check("b2b1_soma", bus.soma, 8'h1E);
      check("b2b1_cout", bus.cout, 1'b0);
`ifdef SOMADOR_OVERFLOW_EN
      check("b2b1_ovf", bus.overflow, 1'b0);
`endif
      @(negedge clk);
      bus.start = 1'b0;
      check("b2b_no_idle", bus.busy, 1'b1);
      wait_done(1, lat);
      check("b2b_spacing", lat, N + 2);
      check("b2b2_soma", bus.soma, 8'h2C);
      check("b2b2_cout", bus.cout, 1'b1);
`ifdef SOMADOR_OVERFLOW_EN
      check("b2b2_ovf", bus.overflow, 1'b0);
`endif
      @(negedge clk);
      check("b2b2_done_pulse", bus.done, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
